// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for param_updown_counter and its prescaler.
//   - MODE_*  : encodings of the 2-bit mode input. The unused code 3 is
//               treated as WRAP by the counter.
//   - state_t : one-shot controller state encoding.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler
//   Divides the enabled clock down to a single-cycle tick every div+1
//   enabled cycles. The phase counter freezes while en is low, so an
//   interrupted interval resumes exactly where it stopped.
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, clears the phase counter
//   en    in   advance enable
//   clr   in   synchronous phase clear (load / accepted start)
//   div   in   divisor minus one; 0 gives a tick on every enabled cycle
//   tick  out  combinational tick, high when en=1 and phase == div
module counter_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] phase;

  assign tick = en & (phase == div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (tick) begin
      phase <= '0;
    end else if (en) begin
      // If div is lowered below the current phase, the counter runs
      // through the wrap of its range before it matches again.
      phase <= phase + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter
//   General-purpose up/down event counter with a programmable upper
//   limit, parallel load, clock prescaler and three end-of-count modes
//   (wrap, saturate, one-shot with start/busy/done handshake).
//
//   Per-cycle priority: rst > load > start > tick step.
//
//   One-shot controller states:
//     state | meaning
//     IDLE  | not running; count holds; also the state outside ONESHOT
//     RUN   | one-shot run in progress; count steps on ticks; busy=1
//     DONE  | run reached the terminal value; count holds; done=1
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   global enable; 0 freezes prescaler, count and FSM
//   up         in   direction, 1 = up, 0 = down
//   mode       in   0 WRAP, 1 SAT, 2 ONESHOT, 3 behaves as WRAP
//   load       in   parallel-load strobe
//   load_val   in   value taken on load
//   limit      in   upper terminal value (lower terminal is 0)
//   presc_div  in   tick every presc_div+1 enabled cycles
//   start      in   one-shot start strobe
//   count      out  registered count
//   tc         out  registered one-cycle terminal-count pulse
//   busy       out  one-shot run in progress
//   done       out  one-shot completed (level)
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               start,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               busy,
  output logic               done
);

  state_t           state;
  state_t           state_n;

  logic             tick;
  logic             oneshot;
  logic             hold_at_end;
  logic             start_acc;
  logic             step_en;
  logic             presc_clr;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;

  // ---------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------
  assign presc_clr = load | start_acc;

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (presc_clr),
    .div  (presc_div),
    .tick (tick)
  );

  // ---------------------------------------------------------------
  // Qualifiers
  // ---------------------------------------------------------------
  always_comb begin
    oneshot     = (mode == MODE_ONESHOT);
    // One-shot runs stop at the end value, so they share the SAT rule.
    hold_at_end = (mode == MODE_SAT) | oneshot;
    // start is only honoured in ONESHOT, outside a run, and below load.
    start_acc   = oneshot & start & ~load & (state != RUN);
    // en is already folded into tick.
    step_en     = tick & ~load & ~start_acc & (~oneshot | (state == RUN));
    term        = up ? limit : '0;
  end

  // ---------------------------------------------------------------
  // Step value for one tick
  // ---------------------------------------------------------------
  always_comb begin
    step_val = count;
    if (up) begin
      // >= so a count left above a lowered limit still wraps or holds.
      if (count >= limit) begin
        step_val = hold_at_end ? count : '0;
      end else begin
        step_val = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        step_val = hold_at_end ? '0 : limit;
      end else begin
        step_val = count - WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------
  // Count / tc next values
  // ---------------------------------------------------------------
  always_comb begin
    count_n = count;
    if (load) begin
      count_n = load_val;
    end else if (start_acc) begin
      count_n = up ? '0 : limit;
    end else if (step_en) begin
      count_n = step_val;
    end
  end

  // tc marks arrival at the terminal value. A value that merely stays on
  // the terminal (SAT hold, limit=0 in WRAP up) does not pulse again; the
  // tick that finishes a one-shot run always pulses.
  assign tc_n = step_en & (step_val == term) & ((step_val != count) | oneshot);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_n;
      tc    <= tc_n;
    end
  end

  // ---------------------------------------------------------------
  // One-shot FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------
  // One-shot FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_n = state;
    if (!oneshot || load) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_acc) state_n = RUN;
        end
        RUN: begin
          // Leaves RUN on the same edge that lands count on the terminal,
          // so busy falls in the cycle count first shows that value.
          if (step_en && (step_val == term)) state_n = DONE;
        end
        DONE: begin
          if (start_acc) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // One-shot FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;
  localparam int CMOD    = 1 << WIDTH;
  localparam int PMOD    = 1 << PRESC_W;

  logic               clk;
  logic               rst;
  logic               en;
  logic               up;
  logic [1:0]         mode;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc_div;
  logic               start;
  logic [WIDTH-1:0]   count;
  logic               tc;
  logic               busy;
  logic               done;

  int n_checks;
  int n_fail;

  // reference model state
  int m_cnt;
  int m_p;
  int m_tc;
  bit m_run;
  bit m_fin;

  param_updown_counter #(
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val),
    .limit     (limit),
    .presc_div (presc_div),
    .start     (start),
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: advances one clock using the inputs currently driven.
  task automatic model_step();
    bit os;
    bit tk;
    bit wraps;
    int nv;
    int t;
    int lim;
    if (rst) begin
      m_cnt = 0; m_p = 0; m_tc = 0; m_run = 0; m_fin = 0;
      return;
    end
    if (load) begin
      m_cnt = int'(load_val); m_p = 0; m_tc = 0; m_run = 0; m_fin = 0;
      return;
    end
    os    = (mode == 2'd2);
    wraps = (mode == 2'd0) || (mode == 2'd3);
    if (!os) begin
      m_run = 0;
      m_fin = 0;
    end
    tk = en && (m_p == int'(presc_div));
    if (en) m_p = tk ? 0 : (m_p + 1) % PMOD;
    m_tc = 0;
    lim  = int'(limit);
    if (os && start && !m_run) begin
      m_cnt = up ? 0 : lim;
      m_p   = 0;
      m_run = 1;
      m_fin = 0;
    end else if (tk && (!os || m_run)) begin
      t = up ? lim : 0;
      if (up) nv = (m_cnt >= lim) ? (wraps ? 0 : m_cnt) : (m_cnt + 1) % CMOD;
      else    nv = (m_cnt == 0) ? (wraps ? lim : 0) : m_cnt - 1;
      if (nv == t && (nv != m_cnt || os)) m_tc = 1;
      if (os && nv == t) begin
        m_run = 0;
        m_fin = 1;
      end
      m_cnt = nv;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".count"}, int'(count), m_cnt);
    check({tag, ".tc"},    int'(tc),    m_tc);
    check({tag, ".busy"},  int'(busy),  int'(m_run));
    check({tag, ".done"},  int'(done),  int'(m_fin));
  endtask

  // Inputs are set at the falling edge before calling; outputs sampled 1
  // time unit after the rising edge, then returns at the next falling edge.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; load = 0; start = 0;
  endtask

  int exp_wrap[8];
  int exp_sat[6];
  int hold_cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_cnt = 0; m_p = 0; m_tc = 0; m_run = 0; m_fin = 0;
    rst = 1; en = 1; up = 1; mode = 2'd2; load = 1; load_val = 8'd9;
    limit = 8'd5; presc_div = '0; start = 1;
    @(negedge clk);

    // reset beats load and start
    cycle("rst_prio");
    check("rst_prio.count0", int'(count), 0);
    check("rst_prio.busy0",  int'(busy),  0);
    cycle("rst_prio2");

    // WRAP up, limit 5
    idle_inputs(); mode = 2'd0; up = 1; limit = 8'd5; presc_div = '0; en = 1;
    exp_wrap = '{1, 2, 3, 4, 5, 0, 1, 2};
    for (int i = 0; i < 8; i++) begin
      cycle("wrap_up");
      check("wrap_up.seq", int'(count), exp_wrap[i]);
      check("wrap_up.tc",  int'(tc),    (exp_wrap[i] == 5) ? 1 : 0);
    end

    // load 3, then SAT down
    load = 1; load_val = 8'd3; mode = 2'd1; up = 0;
    cycle("sat_load");
    check("sat_load.val", int'(count), 3);
    load = 0;
    exp_sat = '{2, 1, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      cycle("sat_down");
      check("sat_down.seq", int'(count), exp_sat[i]);
      check("sat_down.tc",  int'(tc),    (i == 2) ? 1 : 0);
    end

    // prescaler /3 with an en freeze mid-interval
    mode = 2'd0; up = 1; limit = 8'd200; presc_div = 4'd2;
    load = 1; load_val = 8'd0;
    cycle("presc_load");
    load = 0;
    for (int i = 0; i < 6; i++) cycle("presc_run");
    check("presc.after6", int'(count), 2);
    cycle("presc_mid");
    en = 0;
    for (int i = 0; i < 4; i++) cycle("presc_frozen");
    check("presc.frozen", int'(count), 2);
    en = 1;
    cycle("presc_resume1");
    check("presc.resume1", int'(count), 2);
    cycle("presc_resume2");
    check("presc.resume2", int'(count), 3);

    // load coincident with a tick, then prescaler restarts from phase 0
    presc_div = 4'd0;
    load = 1; load_val = 8'd7;
    cycle("load_tick");
    check("load_tick.tc", int'(tc), 0);
    load = 0; presc_div = 4'd2;
    for (int i = 0; i < 3; i++) cycle("load_tick_after");
    check("load_tick.phase", int'(count), 8);

    // load onto the terminal value gives no tc
    presc_div = 4'd0; limit = 8'd9;
    load = 1; load_val = 8'd9;
    cycle("load_term");
    check("load_term.tc", int'(tc), 0);
    load = 0;

    // ONESHOT up, limit 3
    mode = 2'd2; up = 1; limit = 8'd3; start = 1;
    cycle("os_start");
    check("os_start.count", int'(count), 0);
    check("os_start.busy",  int'(busy),  1);
    start = 0;
    for (int i = 0; i < 3; i++) cycle("os_run");
    check("os_end.count", int'(count), 3);
    check("os_end.tc",    int'(tc),    1);
    check("os_end.done",  int'(done),  1);
    check("os_end.busy",  int'(busy),  0);
    cycle("os_hold");
    check("os_hold.count", int'(count), 3);
    start = 1;
    cycle("os_restart");
    check("os_restart.count", int'(count), 0);
    check("os_restart.done",  int'(done),  0);
    cycle("os_start_busy");
    check("os_ignore.count", int'(count), 1);
    start = 0;
    cycle("os_cont");

    // ONESHOT down, limit 4, then leave ONESHOT
    load = 1; load_val = 8'd50;
    cycle("os_load_abort");
    check("os_abort.busy", int'(busy), 0);
    load = 0; up = 0; limit = 8'd4; start = 1;
    cycle("osd_start");
    check("osd_start.count", int'(count), 4);
    start = 0;
    for (int i = 0; i < 4; i++) cycle("osd_run");
    check("osd_end.count", int'(count), 0);
    check("osd_end.done",  int'(done),  1);
    mode = 2'd0;
    cycle("osd_to_wrap");
    check("osd_to_wrap.busy", int'(busy), 0);
    check("osd_to_wrap.done", int'(done), 0);

    // limit 0 with up: tc only when arriving at 0 from non-zero
    up = 1; limit = 8'd0; load = 1; load_val = 8'd2;
    cycle("lim0_load");
    load = 0;
    cycle("lim0_a");
    check("lim0_a.tc", int'(tc), 1);
    cycle("lim0_b");
    check("lim0_b.tc", int'(tc), 0);

    // randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      load      = ($urandom_range(0, 19) == 0);
      start     = ($urandom_range(0, 5) == 0);
      en        = ($urandom_range(0, 4) != 0);
      load_val  = WIDTH'($urandom_range(0, 20));
      if ($urandom_range(0, 15) == 0) begin
        up        = 1'($urandom_range(0, 1));
        mode      = 2'($urandom_range(0, 3));
        limit     = WIDTH'($urandom_range(0, 12));
        presc_div = PRESC_W'($urandom_range(0, 3));
      end
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
